wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Consumer end of the MEM/WB pipeline register in the 16-bit core.
- Selects the writeback value (ALU/forwarded result or main-memory load data), commits it to the 8 x 16 general register file, and commits S/C/Z/V to the architectural flag register.
- Serves the two ID-stage register read ports with write-through bypass, and a bypassed flag view for branch evaluation.
- Keeps a retired-writeback counter for the debug display.

Parameters:
DW, 16, data/register width
NREG, 8, number of general registers
AW, 3, register address width (log2 NREG)
CW, 16, retire counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
en_wb  in  1  stage enable; 0 = pipeline stalled, no architectural commit
regwrite  in  1  instruction in WB writes a register
regwrite_adr  in  AW  destination register
regwrite_dat_wb  in  DW  non-load result
main_mem_dat_wb  in  DW  load data
from_main_mem  in  1  1 = write back load data
flag_we  in  1  instruction in WB updates flags
S_wb, C_wb, Z_wb, V_wb  in  1 each  flag results
ra1, ra2  in  AW  ID read addresses
rd1, rd2  out  DW  ID read data (bypassed)
wb_dat  out  DW  selected writeback value (to forwarding mux)
S, C, Z, V  out  1 each  architectural flags (registered)
S_fwd, C_fwd, Z_fwd, V_fwd  out  1 each  bypassed flags
retire_cnt  out  CW  committed register writes

Behaviour:
- Writeback select is combinational: wb_dat = from_main_mem ? main_mem_dat_wb : regwrite_dat_wb.
- Register commit:
  - On the rising edge with en_wb=1 and regwrite=1, rf[regwrite_adr] <= wb_dat.
  - With en_wb=0, nothing commits, even if regwrite=1.
- Read ports are combinational, with zero-cycle latency.
  - rdN = wb_dat when regwrite=1 and raN==regwrite_adr; otherwise rdN = rf[raN].
  - The bypass is gated by regwrite only, not en_wb. A stalled WB instruction still holds valid data and commits later.
  - Both ports may bypass in the same cycle, including when ra1==ra2==regwrite_adr.
- Flag commit:
  - On the rising edge with en_wb=1 and flag_we=1, {S,C,Z,V} <= {S_wb,C_wb,Z_wb,V_wb}.
  - Otherwise the flags hold.
  - regwrite and flag_we are independent; both may commit on the same edge.
- Flag bypass: *_fwd = *_wb when flag_we=1, else the registered flag.
- Retire counter:
  - Increments by 1 on each edge with en_wb=1 and regwrite=1.
  - Wraps 0xFFFF -> 0x0000 with no saturation and no flag.
- Reset (reset=0, asynchronous):
  - All rf entries = 0; S=C=Z=V=0; retire_cnt=0.
  - Combinational outputs follow from the cleared state: with regwrite=0, rd1=rd2=0 and *_fwd=0.
- Reset mid-operation: a write presented in the cycle reset asserts is lost. The first commit occurs on the first rising edge with reset=1.
- No register is hard-wired to zero; register 0 is writable.
- Out-of-range addresses cannot occur (AW = log2 NREG).
- No X propagation: every storage element has a reset value.

Decomposition:
- Shared package (core_pkg):
  - DW, AW, NREG constants.
  - typedef logic [AW-1:0] regadr_t.
  - typedef logic [DW-1:0] word_t.
  - packed struct flags_t {S,C,Z,V} (bit order fixed S,C,Z,V MSB to LSB).
- One natural sub-module, wb_regfile: 2-read/1-write array with write enable and the write-through bypass.
- Flag register, writeback mux and retire counter stay in wb_stage.

Test Plan:
- Reset then release; read ra1=0..7 with regwrite=0 -> rd1=0x0000 for all; S,C,Z,V=0; retire_cnt=0.
- regwrite=1, adr=3, from_main_mem=0, regwrite_dat_wb=0x1234, en_wb=1, ra1=3 -> rd1=0x1234 same cycle (bypass). Next cycle, regwrite=0 -> rd1=0x1234 from rf; retire_cnt=1.
- from_main_mem=1, main_mem_dat_wb=0xBEEF, regwrite_dat_wb=0x0F0F, adr=5, ra1=ra2=5 -> wb_dat=rd1=rd2=0xBEEF; rf[5]=0xBEEF after the edge.
- en_wb=0 for 3 cycles with regwrite=1, adr=2, data 0xAAAA -> rd(2) bypasses 0xAAAA while rf[2] stays 0 and retire_cnt is unchanged. Raise en_wb -> rf[2]=0xAAAA; retire_cnt increments exactly once.
- Flags: flag_we=1 with S/C/Z/V=1/0/1/0 -> *_fwd=1010 immediately and S..V=1010 after the edge. Then flag_we=0 with inputs 0101 -> flags stay 1010.
- Preload retire_cnt to 0xFFFF with committed writes, then do one more commit -> 0x0000. Assert reset mid-write (adr=7, data 0x5555) -> rf[7]=0 after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the 16-bit core pipeline.
package core_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;

  typedef logic [AW-1:0] regadr_t;
  typedef logic [DW-1:0] word_t;

  // Bit order S,C,Z,V from MSB to LSB.
  typedef struct packed {
    logic s;
    logic c;
    logic z;
    logic v;
  } flags_t;

endpackage

// File: rtl/wb_regfile.sv
// General register file: 2 combinational read ports, 1 write port,
// with write-through bypass of the value currently in WB.
module wb_regfile
  import core_pkg::*;
#(
  parameter int DW   = core_pkg::DW,
  parameter int NREG = core_pkg::NREG,
  parameter int AW   = core_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          byp_en,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdat,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2
);

  logic [NREG-1:0][DW-1:0] rf_q;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [DW-1:0] q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        q <= '0;
      end else if (we && (wadr == AW'(gi))) begin
        q <= wdat;
      end
    end

    assign rf_q[gi] = q;
  end

  // Bypass follows regwrite alone so a stalled instruction is still visible.
  assign rd1 = (byp_en && (ra1 == wadr)) ? wdat : rf_q[ra1];
  assign rd2 = (byp_en && (ra2 == wadr)) ? wdat : rf_q[ra2];

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, register/flag commit, bypassed read
// ports for ID, and a retired-writeback counter.
module wb_stage
  import core_pkg::*;
#(
  parameter int DW   = core_pkg::DW,
  parameter int NREG = core_pkg::NREG,
  parameter int AW   = core_pkg::AW,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_wb,
  input  logic          regwrite,
  input  logic [AW-1:0] regwrite_adr,
  input  logic [DW-1:0] regwrite_dat_wb,
  input  logic [DW-1:0] main_mem_dat_wb,
  input  logic          from_main_mem,
  input  logic          flag_we,
  input  logic          S_wb,
  input  logic          C_wb,
  input  logic          Z_wb,
  input  logic          V_wb,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic [DW-1:0] wb_dat,
  output logic          S,
  output logic          C,
  output logic          Z,
  output logic          V,
  output logic          S_fwd,
  output logic          C_fwd,
  output logic          Z_fwd,
  output logic          V_fwd,
  output logic [CW-1:0] retire_cnt
);

  flags_t        flags_q, flags_d, flags_in, flags_fwd;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          commit_reg;

  assign wb_dat     = from_main_mem ? main_mem_dat_wb : regwrite_dat_wb;
  assign commit_reg = en_wb & regwrite;

  wb_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (commit_reg),
    .byp_en (regwrite),
    .wadr   (regwrite_adr),
    .wdat   (wb_dat),
    .ra1    (ra1),
    .ra2    (ra2),
    .rd1    (rd1),
    .rd2    (rd2)
  );

  assign flags_in = '{s: S_wb, c: C_wb, z: Z_wb, v: V_wb};

  always_comb begin
    flags_d = flags_q;
    cnt_d   = cnt_q;
    if (en_wb && flag_we) begin
      flags_d = flags_in;
    end
    if (commit_reg) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flags_fwd = flag_we ? flags_in : flags_q;

  assign S          = flags_q.s;
  assign C          = flags_q.c;
  assign Z          = flags_q.z;
  assign V          = flags_q.v;
  assign S_fwd      = flags_fwd.s;
  assign C_fwd      = flags_fwd.c;
  assign Z_fwd      = flags_fwd.z;
  assign V_fwd      = flags_fwd.v;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus queues expectations, a negedge
// monitor pops and compares them against the live outputs.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en_wb = 1'b0;
  logic        regwrite = 1'b0;
  logic [2:0]  regwrite_adr = '0;
  logic [15:0] regwrite_dat_wb = '0;
  logic [15:0] main_mem_dat_wb = '0;
  logic        from_main_mem = 1'b0;
  logic        flag_we = 1'b0;
  logic        S_wb = 1'b0, C_wb = 1'b0, Z_wb = 1'b0, V_wb = 1'b0;
  logic [2:0]  ra1 = '0, ra2 = '0;
  logic [15:0] rd1, rd2, wb_dat, retire_cnt;
  logic        S, C, Z, V, S_fwd, C_fwd, Z_fwd, V_fwd;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk             (clk),
    .reset           (reset),
    .en_wb           (en_wb),
    .regwrite        (regwrite),
    .regwrite_adr    (regwrite_adr),
    .regwrite_dat_wb (regwrite_dat_wb),
    .main_mem_dat_wb (main_mem_dat_wb),
    .from_main_mem   (from_main_mem),
    .flag_we         (flag_we),
    .S_wb            (S_wb),
    .C_wb            (C_wb),
    .Z_wb            (Z_wb),
    .V_wb            (V_wb),
    .ra1             (ra1),
    .ra2             (ra2),
    .rd1             (rd1),
    .rd2             (rd2),
    .wb_dat          (wb_dat),
    .S               (S),
    .C               (C),
    .Z               (Z),
    .V               (V),
    .S_fwd           (S_fwd),
    .C_fwd           (C_fwd),
    .Z_fwd           (Z_fwd),
    .V_fwd           (V_fwd),
    .retire_cnt      (retire_cnt)
  );

  typedef enum int {K_RD1, K_RD2, K_WBDAT, K_FLAGS, K_FWD, K_CNT} kind_t;

  typedef struct {
    kind_t       kind;
    logic [15:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [15:0] exp_cnt = '0;

  function automatic logic [15:0] observe(kind_t k);
    case (k)
      K_RD1:   return rd1;
      K_RD2:   return rd2;
      K_WBDAT: return wb_dat;
      K_FLAGS: return {12'd0, S, C, Z, V};
      K_FWD:   return {12'd0, S_fwd, C_fwd, Z_fwd, V_fwd};
      default: return retire_cnt;
    endcase
  endfunction

  // Monitor: every expectation queued during a cycle is checked at its negedge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      item_t it;
      logic [15:0] act;
      it  = q.pop_front();
      act = observe(it.kind);
      n_cmp++;
      if (act !== it.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%04h expected 0x%04h", it.name, act, it.exp);
      end else begin
        $display("ok   %s = 0x%04h", it.name, act);
      end
    end
  end

  task automatic expect_val(kind_t k, logic [15:0] v, string nm);
    item_t it;
    it.kind = k;
    it.exp  = v;
    it.name = nm;
    q.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(logic en, logic we, logic [2:0] adr, logic [15:0] dat);
    en_wb           = en;
    regwrite        = we;
    regwrite_adr    = adr;
    regwrite_dat_wb = dat;
    from_main_mem   = 1'b0;
  endtask

  initial begin
    // Reset state, sampled while reset is held.
    step();
    expect_val(K_RD1, 16'h0000, "reset_rd1");
    expect_val(K_FLAGS, 16'h0000, "reset_flags");
    expect_val(K_FWD, 16'h0000, "reset_fwd");
    expect_val(K_CNT, 16'h0000, "reset_cnt");
    step();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i);
      expect_val(K_RD1, 16'h0000, $sformatf("clear_rd1_r%0d", i));
      step();
    end

    // ALU writeback with same-cycle bypass.
    set_wr(1'b1, 1'b1, 3'd3, 16'h1234);
    ra1 = 3'd3;
    ra2 = 3'd4;
    expect_val(K_RD1, 16'h1234, "bypass_rd1_r3");
    expect_val(K_RD2, 16'h0000, "nobypass_rd2_r4");
    expect_val(K_WBDAT, 16'h1234, "wbdat_alu");
    step();
    exp_cnt++;
    set_wr(1'b1, 1'b0, 3'd3, 16'h0000);
    expect_val(K_RD1, 16'h1234, "rf_rd1_r3");
    expect_val(K_CNT, exp_cnt, "cnt_after_r3");
    step();

    // Load writeback, both ports bypassing the same register.
    set_wr(1'b1, 1'b1, 3'd5, 16'h0F0F);
    from_main_mem   = 1'b1;
    main_mem_dat_wb = 16'hBEEF;
    ra1 = 3'd5;
    ra2 = 3'd5;
    expect_val(K_WBDAT, 16'hBEEF, "wbdat_load");
    expect_val(K_RD1, 16'hBEEF, "bypass_rd1_r5");
    expect_val(K_RD2, 16'hBEEF, "bypass_rd2_r5");
    step();
    exp_cnt++;
    set_wr(1'b1, 1'b0, 3'd0, 16'h0000);
    expect_val(K_RD1, 16'hBEEF, "rf_rd1_r5");
    expect_val(K_RD2, 16'hBEEF, "rf_rd2_r5");
    expect_val(K_CNT, exp_cnt, "cnt_after_r5");
    step();

    // Stall: bypass visible, no commit.
    ra1 = 3'd2;
    ra2 = 3'd3;
    for (int i = 0; i < 3; i++) begin
      set_wr(1'b0, 1'b1, 3'd2, 16'hAAAA);
      expect_val(K_RD1, 16'hAAAA, $sformatf("stall_bypass_%0d", i));
      expect_val(K_RD2, 16'h1234, $sformatf("stall_rd2_%0d", i));
      expect_val(K_CNT, exp_cnt, $sformatf("stall_cnt_%0d", i));
      step();
    end
    set_wr(1'b0, 1'b0, 3'd2, 16'hAAAA);
    expect_val(K_RD1, 16'h0000, "stall_rf_r2_unwritten");
    step();
    set_wr(1'b1, 1'b1, 3'd2, 16'hAAAA);
    step();
    exp_cnt++;
    set_wr(1'b1, 1'b0, 3'd0, 16'h0000);
    expect_val(K_RD1, 16'hAAAA, "release_rf_r2");
    expect_val(K_CNT, exp_cnt, "release_cnt_once");
    step();

    // Flags: commit, hold when flag_we=0, no commit while stalled.
    flag_we = 1'b1;
    {S_wb, C_wb, Z_wb, V_wb} = 4'b1010;
    expect_val(K_FWD, 16'h000A, "fwd_1010");
    expect_val(K_FLAGS, 16'h0000, "flags_before_edge");
    step();
    flag_we = 1'b0;
    {S_wb, C_wb, Z_wb, V_wb} = 4'b0101;
    expect_val(K_FLAGS, 16'h000A, "flags_1010");
    expect_val(K_FWD, 16'h000A, "fwd_hold_1010");
    step();
    expect_val(K_FLAGS, 16'h000A, "flags_hold");
    en_wb   = 1'b0;
    flag_we = 1'b1;
    expect_val(K_FWD, 16'h0005, "fwd_stalled_0101");
    step();
    flag_we = 1'b0;
    en_wb   = 1'b1;
    expect_val(K_FLAGS, 16'h000A, "flags_stall_no_commit");
    step();

    // Register 0 is an ordinary register; also commit flags alongside.
    set_wr(1'b1, 1'b1, 3'd0, 16'h7777);
    flag_we = 1'b1;
    step();
    exp_cnt++;
    flag_we = 1'b0;
    set_wr(1'b1, 1'b0, 3'd0, 16'h0000);
    ra1 = 3'd0;
    expect_val(K_RD1, 16'h7777, "rf_r0_writable");
    expect_val(K_FLAGS, 16'h0005, "flags_with_regwrite");
    expect_val(K_CNT, exp_cnt, "cnt_after_r0");
    step();

    // Drive the retire counter up to 0xFFFF, then wrap.
    while (exp_cnt != 16'hFFFF) begin
      set_wr(1'b1, 1'b1, 3'd1, exp_cnt);
      step();
      exp_cnt++;
    end
    set_wr(1'b1, 1'b0, 3'd0, 16'h0000);
    ra1 = 3'd1;
    expect_val(K_CNT, 16'hFFFF, "cnt_at_ffff");
    expect_val(K_RD1, 16'hFFFE, "rf_r1_last");
    step();
    set_wr(1'b1, 1'b1, 3'd6, 16'h0001);
    step();
    exp_cnt++;
    set_wr(1'b1, 1'b0, 3'd0, 16'h0000);
    expect_val(K_CNT, exp_cnt, "cnt_wrap_0000");
    step();

    // Reset asserted mid-write: the write is lost.
    set_wr(1'b1, 1'b1, 3'd7, 16'h5555);
    ra1 = 3'd7;
    #2;
    reset = 1'b0;
    step();
    set_wr(1'b1, 1'b0, 3'd0, 16'h0000);
    step();
    reset = 1'b1;
    expect_val(K_RD1, 16'h0000, "reset_lost_r7");
    expect_val(K_CNT, 16'h0000, "reset_cnt_cleared");
    expect_val(K_FLAGS, 16'h0000, "reset_flags_cleared");
    expect_val(K_FWD, 16'h0000, "reset_fwd_cleared");
    step();
    // First commit after release lands on the first rising edge.
    set_wr(1'b1, 1'b1, 3'd7, 16'h5555);
    step();
    set_wr(1'b1, 1'b0, 3'd0, 16'h0000);
    expect_val(K_RD1, 16'h5555, "post_reset_r7");
    expect_val(K_CNT, 16'h0001, "post_reset_cnt");
    step();
    step();

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
